// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment to binary converter.
// Segment codes are active-low, bit0 = segment a through bit6 = segment g.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS_DEFAULT = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment code to BCD digit decoder.
// Macro SEG7_BLANK_AS_ZERO_EN: when defined, the all-off code is a valid 0.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       code_ok
);

`ifdef SEG7_BLANK_AS_ZERO_EN
  localparam logic BLANK_OK = 1'b1;
`else
  localparam logic BLANK_OK = 1'b0;
`endif

  // Unrecognised codes report digit 0 so the accumulator stays well defined.
  always_comb begin
    digit   = 4'd0;
    code_ok = 1'b1;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: code_ok = BLANK_OK;
      default:   code_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_binary.sv
// Accumulates a stream of seven-segment digits (MSD first) into an 8-bit value
// with a ready/valid result handshake. Blank handling set by SEG7_BLANK_AS_ZERO_EN.
//
// state | meaning
// IDLE  | no digit of the current number accepted yet
// ACCUM | at least one digit accepted, waiting for the last one
// DONE  | result presented on bin_o/err_o, waiting for bin_ready_i
module seg7_to_binary
  import seg7_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       seg_valid_i,
  input  logic [6:0] seg_i,
  input  logic       last_i,
  output logic       seg_ready_o,
  output logic       bin_valid_o,
  output logic [7:0] bin_o,
  output logic       err_o,
  input  logic       bin_ready_i
);

  localparam int unsigned       CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic             accept, clear;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       bin_q;
  logic             err_out_q;
  logic [3:0]       digit;
  logic             code_ok;
  logic [11:0]      acc_next_w;

  seg7_decode u_decode (
    .seg     (seg_i),
    .digit   (digit),
    .code_ok (code_ok)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    seg_ready_o = 1'b1;
    bin_valid_o = 1'b0;
    accept      = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        accept = seg_valid_i;
        if (seg_valid_i) state_d = last_i ? DONE : ACCUM;
      end
      DONE: begin
        seg_ready_o = 1'b0;
        bin_valid_o = 1'b1;
        clear       = bin_ready_i;
        if (bin_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wide enough that acc*10+9 never wraps, so the >255 test is exact.
  assign acc_next_w = 12'(acc_q) * 12'd10 + 12'(digit);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (cnt_q >= CNT_MAX) begin
      err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (!code_ok) err_d = 1'b1;
      if (acc_next_w > 12'd255) begin
        acc_d = 8'hFF;
        err_d = 1'b1;
      end else begin
        acc_d = acc_next_w[7:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_q     <= '0;
      err_out_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (last_i) begin
        bin_q     <= acc_d;
        err_out_q <= err_d;
      end
    end
  end

  assign bin_o = bin_q;
  assign err_o = err_out_q;

endmodule
